// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO block: register offsets, word-index decode and
// parameter limits.
package gpio_pkg;

  localparam logic [4:0] GPIO_DIR  = 5'h00;
  localparam logic [4:0] GPIO_IDR  = 5'h04;
  localparam logic [4:0] GPIO_ODR  = 5'h08;
  localparam logic [4:0] GPIO_SET  = 5'h0C;
  localparam logic [4:0] GPIO_CLR  = 5'h10;
  localparam logic [4:0] GPIO_IER  = 5'h14;
  localparam logic [4:0] GPIO_EDGE = 5'h18;
  localparam logic [4:0] GPIO_ISR  = 5'h1C;

  localparam int unsigned WidthMin      = 1;
  localparam int unsigned WidthMax      = 32;
  localparam int unsigned SyncStagesMin = 2;
  localparam int unsigned SyncStagesMax = 4;

  typedef enum logic [2:0] {
    RegDir  = 3'd0,
    RegIdr  = 3'd1,
    RegOdr  = 3'd2,
    RegSet  = 3'd3,
    RegClr  = 3'd4,
    RegIer  = 3'd5,
    RegEdge = 3'd6,
    RegIsr  = 3'd7
  } gpio_reg_e;

  // Only a write to IDR or a read of SET/CLR is rejected.
  function automatic logic gpio_access_err(input gpio_reg_e reg_sel, input logic write);
    if (write) return reg_sel == RegIdr;
    return (reg_sel == RegSet) || (reg_sel == RegClr);
  endfunction

endpackage

// File: rtl/apb_gpio_irq_if.sv
// APB3 slave-side bus bundle for the GPIO block (5-bit byte address, 32-bit data).
interface apb_gpio_irq_if;
  logic [4:0]  PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/gpio_sync_edge.sv
// Multi-stage pin synchroniser; with GPIO_IRQ_EN it also keeps a one-cycle delayed copy
// and produces per-bit rise/fall pulses.
module gpio_sync_edge #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] sync
`ifdef GPIO_IRQ_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= pins;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) prev_q <= '0;
    else         prev_q <= sync;
  end

  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;
`endif

endmodule

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO peripheral with direction, atomic set/clear and synchronised inputs.
// Edge interrupts (IER/EDGE/ISR) exist only when GPIO_IRQ_EN is defined.
module apb_gpio_irq
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_gpio_irq_if.slave        apb,
  input  logic [WIDTH-1:0]     gpio_i,
  output logic [WIDTH-1:0]     gpio_o,
  output logic [WIDTH-1:0]     gpio_oe,
  output logic                 irq
);

  gpio_reg_e        reg_sel;
  logic             access_start;
  logic             commit;
  logic             access_err;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sync;
  logic [31:0]      rdata;

  logic             ready_q, ready_d;
  logic             slverr_q, slverr_d;
  logic [31:0]      prdata_q, prdata_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] odr_q, odr_d;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{apb.PADDR[1:0], apb.PWDATA};

  assign reg_sel      = gpio_reg_e'(apb.PADDR[4:2]);
  assign wdata        = apb.PWDATA[WIDTH-1:0];
  assign access_err   = gpio_access_err(reg_sel, apb.PWRITE);
  assign access_start = apb.PSEL & apb.PENABLE & ~ready_q;
  // Erroring transfers never commit; slverr_q still holds this transfer's verdict.
  assign commit       = apb.PSEL & apb.PENABLE & ready_q & apb.PWRITE & ~slverr_q;

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] rise, fall;
  logic [WIDTH-1:0] ier_q, ier_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] isr_q, isr_d;
  logic [WIDTH-1:0] w1c;
`endif

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .pins   (gpio_i),
    .sync   (sync)
`ifdef GPIO_IRQ_EN
    ,
    .rise   (rise),
    .fall   (fall)
`endif
  );

  always_comb begin
    rdata = '0;
    case (reg_sel)
      RegDir:  rdata[WIDTH-1:0] = dir_q;
      RegIdr:  rdata[WIDTH-1:0] = sync;
      RegOdr:  rdata[WIDTH-1:0] = odr_q;
`ifdef GPIO_IRQ_EN
      RegIer:  rdata[WIDTH-1:0] = ier_q;
      RegEdge: rdata[WIDTH-1:0] = edge_q;
      RegIsr:  rdata[WIDTH-1:0] = isr_q;
`endif
      default: rdata = '0;
    endcase
  end

  always_comb begin
    ready_d  = access_start;
    slverr_d = access_start & access_err;
    prdata_d = prdata_q;
    if (access_start) prdata_d = access_err ? '0 : rdata;
  end

  always_comb begin
    dir_d = dir_q;
    odr_d = odr_q;
    if (commit) begin
      case (reg_sel)
        RegDir:  dir_d = wdata;
        RegOdr:  odr_d = wdata;
        RegSet:  odr_d = odr_q | wdata;
        RegClr:  odr_d = odr_q & ~wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      prdata_q <= '0;
      dir_q    <= '0;
      odr_q    <= '0;
    end else begin
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      prdata_q <= prdata_d;
      dir_q    <= dir_d;
      odr_q    <= odr_d;
    end
  end

`ifdef GPIO_IRQ_EN
  always_comb begin
    ier_d  = ier_q;
    edge_d = edge_q;
    w1c    = '0;
    if (commit) begin
      case (reg_sel)
        RegIer:  ier_d  = wdata;
        RegEdge: edge_d = wdata;
        RegIsr:  w1c    = wdata;
        default: ;
      endcase
    end
    // New events are ORed in after the clear so a same-edge event survives.
    isr_d = (isr_q & ~w1c) | (rise & edge_q) | (fall & ~edge_q);
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      ier_q  <= '0;
      edge_q <= '0;
      isr_q  <= '0;
    end else begin
      ier_q  <= ier_d;
      edge_q <= edge_d;
      isr_q  <= isr_d;
    end
  end

  assign irq = |(isr_q & ier_q);
`else
  assign irq = 1'b0;
`endif

  assign apb.PREADY  = ready_q;
  assign apb.PSLVERR = slverr_q;
  assign apb.PRDATA  = prdata_q;
  assign gpio_o      = odr_q;
  assign gpio_oe     = dir_q;

endmodule

// File: doc/apb_gpio_irq.md
# apb_gpio_irq

Parametrised APB3 GPIO peripheral: WIDTH independent pins, each with direction control, atomic set/clear of outputs, a multi-stage input synchroniser and optional edge-triggered interrupts. Sits on the APB slave bus beside the other peripherals. Pad tristating is done in the top-level pad ring from `gpio_o`/`gpio_oe`; the block itself has no inout ports.

## Interface
- `WIDTH`, 8 — number of pins, 1..32
- `SYNC_STAGES`, 2 — input synchroniser flops, 2..4
- `PCLK` in 1 — sole clock, all logic on rising edge
- `PRESET` in 1 — reset, asynchronous, active-low (asserted when 0)
- `PADDR` in 5 — byte address; decoded on `PADDR[4:2]`
- `PWRITE` in 1 — 1 = write
- `PSEL` in 1 — slave select
- `PENABLE` in 1 — access phase
- `PWDATA` in 32 — write data; bits ≥ WIDTH ignored
- `PRDATA` out 32 — read data, registered; bits ≥ WIDTH read 0
- `PREADY` out 1 — transfer complete, registered
- `PSLVERR` out 1 — error response, valid with `PREADY`
- `gpio_i` in WIDTH — raw asynchronous pin inputs
- `gpio_o` out WIDTH — output data (= ODR)
- `gpio_oe` out WIDTH — output enable (= DIR)
- `irq` out 1 — level interrupt, |(ISR & IER)

## Operation
- Register map (offset, access):
  - 0x00 DIR RW — 1 = output
  - 0x04 IDR RO — synchronised pin state
  - 0x08 ODR RW
  - 0x0C SET WO — ODR |= wdata; reads 0
  - 0x10 CLR WO — ODR &= ~wdata; reads 0
  - 0x14 IER RW
  - 0x18 EDGE RW — 1 = rising, 0 = falling
  - 0x1C ISR RW1C
- IDR reflects the pin for every bit regardless of DIR; an output pin reads back its own driven value through the pad.
- Edge event per bit: rising = s & ~p, falling = ~s & p, where s is the last synchroniser stage and p is s delayed one cycle. A selected event sets ISR[i] regardless of IER[i].
- ISR write-1-to-clear. If an event and a W1C hit the same bit on the same edge, set wins.
- PSLVERR=1 (with PREADY, no state change) for: offsets 0x20–0x3F are unreachable with a 5-bit address, so the error cases are a write to IDR and a read of SET/CLR. All other accesses return PSLVERR=0.
- Reset values: all registers 0; synchroniser and p flops 0; PRDATA=0, PREADY=0, PSLVERR=0, gpio_o=0, gpio_oe=0, irq=0.
- A pin held high across reset release produces a rising event within SYNC_STAGES+1 cycles. Because IER=0, irq stays low. Software clears ISR before setting IER.

## Timing
- One wait state per transfer:
  - setup cycle (PSEL, !PENABLE)
  - first access cycle: PREADY=0
  - on that edge the block registers PREADY=1, PRDATA and PSLVERR
  - second access cycle completes the transfer
  - PREADY returns to 0 on the following edge
- PREADY rises only when PSEL & PENABLE & !PREADY.
- Write commits on the edge where PSEL & PENABLE & PREADY & PWRITE; exactly one commit per transfer.
- Read data sampled from register state at the first access edge.
- gpio_o/gpio_oe change on the commit edge, visible the cycle after.
- Pin-to-IDR latency: SYNC_STAGES edges. Pin-to-ISR/irq: SYNC_STAGES+1 edges. irq is combinational from ISR/IER flops and glitch-free.
- PRESET asserted mid-transfer: all state clears immediately and the transfer is abandoned with PREADY=0.

## Configuration
- `GPIO_IRQ_EN` defined: IER/EDGE/ISR and the edge detector are implemented as above.
- Not defined:
  - IER/EDGE/ISR read 0; writes are accepted (PSLVERR=0) and ignored
  - no p flops or event logic synthesised
  - irq tied 0
  - DIR/IDR/ODR/SET/CLR unchanged

## Structure
- Package `gpio_pkg`: register offset localparams (GPIO_DIR … GPIO_ISR), a `gpio_reg_e` enum on `PADDR[4:2]`, and WIDTH/SYNC_STAGES limits.
- Sub-module `gpio_sync_edge`:
  - WIDTH-wide SYNC_STAGES synchroniser plus the p flop
  - outputs `sync` and `rise`/`fall` vectors
  - edge outputs exist only under `GPIO_IRQ_EN`

## Test plan
- Reset: PRESET=0 mid-write to ODR → all outputs 0; after release ODR reads 0x00, PREADY pulses once per transfer.
- Direction/output: write DIR=0xF0, ODR=0xA5 → gpio_oe=0xF0, gpio_o=0xA5; SET 0x0A → ODR 0xAF; CLR 0x81 → ODR 0x2E.
- Sync latency (SYNC_STAGES=2): gpio_i 0x00→0x3C at edge N → IDR reads 0x3C from edge N+2, not before.
- Edge irq: EDGE=0x01, IER=0x03; toggle bit0 0→1 and bit1 1→0 → ISR=0x03, irq=1 at N+3; W1C 0x01 → ISR=0x02, irq stays 1; W1C 0x02 → irq=0.
- Set-wins: bit0 rising event on the same edge as W1C 0x01 → ISR[0]=1.
- Errors: write IDR, read SET → PSLVERR=1, no register change; read ODR → PSLVERR=0. Rebuild without `GPIO_IRQ_EN` → ISR reads 0, irq=0 under toggling.
